// File: rtl/core_out_pkg.sv
// Shared types and sizing helpers for the core output serializer.
package core_out_pkg;

  typedef enum logic {IDLE, DRAIN} state_t;

  function automatic int calc_cw(input int width, input int chunk_size);
    return width * chunk_size;
  endfunction

  function automatic int calc_idx_w(input int num_cores);
    return (num_cores > 1) ? $clog2(num_cores) : 1;
  endfunction

endpackage

// File: rtl/core_out_serializer_if.sv
// Valid/ready stream carrying one core chunk per beat out of the serializer.
interface core_out_serializer_if #(parameter int CW = 64);

  logic [CW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;

  modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);

endinterface

// File: rtl/core_out_serializer_chunk_mux.sv
// Selects one CW-wide core chunk out of a held snapshot by chunk index.
module chunk_mux
  import core_out_pkg::*;
#(
  parameter int CW        = 64,
  parameter int NUM_CORES = 2,
  parameter int IW        = 1
)(
  input  logic [CW*NUM_CORES-1:0] slot_i,
  input  logic [IW-1:0]           idx_i,
  output logic [CW-1:0]           chunk_o
);

  always_comb begin
    chunk_o = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (idx_i == IW'(i)) chunk_o = slot_i[i*CW +: CW];
    end
  end

endmodule

// File: rtl/core_out_serializer.sv
// Snapshots the multi-core array output on acc_done and streams it chunk by chunk.
// Define CORE_OUT_DBUF_EN for a second (ping-pong) snapshot slot.
module core_out_serializer
  import core_out_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CHUNK_SIZE = 4,
  parameter int NUM_CORES  = 2,
  localparam int CW        = calc_cw(WIDTH, CHUNK_SIZE)
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    acc_done,
  input  logic [CW*NUM_CORES-1:0] in_data,
  output logic                    reset_acc,
  core_out_serializer_if.master   m,
  output logic                    busy,
  output logic                    overflow
);

`ifdef CORE_OUT_DBUF_EN
  localparam int NSLOT = 2;
`else
  localparam int NSLOT = 1;
`endif
  localparam int IW = calc_idx_w(NUM_CORES);
  localparam int BW = CW * NUM_CORES;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CORES - 1);

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [NSLOT-1:0] vld_q, vld_d;
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic [BW-1:0]    slot_q [NSLOT];
  logic             acc_done_q;
  logic             m_tvalid_q;
  logic             reset_acc_q;
  logic             overflow_q;
  logic             capture, hs, last_hs, accept;

  // A final handshake frees its slot in the same cycle, so a capture then is never dropped.
  always_comb begin
    capture = acc_done & ~acc_done_q;
    hs      = m_tvalid_q & m.m_tready;
    last_hs = hs & (idx_q == LAST_IDX);
    accept  = capture & (~(&vld_q) | last_hs);

    vld_d = vld_q;
    if (last_hs) vld_d[rd_q] = 1'b0;
    if (accept)  vld_d[wr_q] = 1'b1;

    rd_d = rd_q;
    wr_d = wr_q;
    if (last_hs && NSLOT > 1) rd_d = ~rd_q;
    if (accept && NSLOT > 1)  wr_d = ~wr_q;

    idx_d = idx_q;
    if (hs) idx_d = last_hs ? '0 : idx_q + IW'(1);

    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = DRAIN;
      DRAIN:   if (last_hs && !(|vld_d)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      vld_q       <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      acc_done_q  <= 1'b1;
      m_tvalid_q  <= 1'b0;
      reset_acc_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      vld_q       <= vld_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      acc_done_q  <= acc_done;
      m_tvalid_q  <= (state_d == DRAIN);
      reset_acc_q <= accept;
      overflow_q  <= overflow_q | (capture & ~accept);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSLOT; i++) slot_q[i] <= '0;
    end else if (accept) begin
      slot_q[wr_q] <= in_data;
    end
  end

  chunk_mux #(
    .CW        (CW),
    .NUM_CORES (NUM_CORES),
    .IW        (IW)
  ) u_chunk_mux (
    .slot_i  (slot_q[rd_q]),
    .idx_i   (idx_q),
    .chunk_o (m.m_tdata)
  );

  assign m.m_tvalid = m_tvalid_q;
  assign m.m_tlast  = m_tvalid_q & (idx_q == LAST_IDX);
  assign reset_acc  = reset_acc_q;
  assign overflow   = overflow_q;
  assign busy       = |vld_q;

endmodule

// File: tb/tb_core_out_serializer.sv
// Directed self-checking bench for core_out_serializer (WIDTH=16, CHUNK_SIZE=4, NUM_CORES=2).
module tb_core_out_serializer;

  localparam int CW = 64;
  localparam logic [CW-1:0] A = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [CW-1:0] B = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [CW-1:0] C = 64'hCCCC_CCCC_CCCC_CCCC;
  localparam logic [CW-1:0] D = 64'hDDDD_DDDD_DDDD_DDDD;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           acc_done;
  logic [2*CW-1:0] in_data;
  logic           reset_acc;
  logic           busy;
  logic           overflow;
  int             checks = 0;
  int             errors = 0;

  core_out_serializer_if #(.CW(CW)) sif();

  core_out_serializer #(
    .WIDTH      (16),
    .CHUNK_SIZE (4),
    .NUM_CORES  (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .acc_done  (acc_done),
    .in_data   (in_data),
    .reset_acc (reset_acc),
    .m         (sif),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; acc_done = 1'b1; sif.m_tready = 1'b0; in_data = '0;
    step(); step();
    checks++; if (sif.m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid got %b want 0", sif.m_tvalid); end
    checks++; if (sif.m_tlast !== 1'b0) begin errors++; $display("[TB] FAIL reset_tlast got %b want 0", sif.m_tlast); end
    checks++; if (sif.m_tdata !== '0) begin errors++; $display("[TB] FAIL reset_tdata got %h want 0", sif.m_tdata); end
    checks++; if (reset_acc !== 1'b0) begin errors++; $display("[TB] FAIL reset_racc got %b want 0", reset_acc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got %b want 0", overflow); end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (reset_acc !== 1'b0) begin errors++; $display("[TB] FAIL held_level_racc got %b want 0", reset_acc); end
      checks++; if (sif.m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL held_level_tvalid got %b want 0", sif.m_tvalid); end
    end
    acc_done = 1'b0;
    step();
  endtask

  task automatic test_basic();
    in_data = {B, A}; sif.m_tready = 1'b1; acc_done = 1'b1;
    step();
    checks++; if (sif.m_tvalid !== 1'b1) begin errors++; $display("[TB] FAIL basic_t1_tvalid got %b want 1", sif.m_tvalid); end
    checks++; if (sif.m_tdata !== A) begin errors++; $display("[TB] FAIL basic_t1_tdata got %h want %h", sif.m_tdata, A); end
    checks++; if (sif.m_tlast !== 1'b0) begin errors++; $display("[TB] FAIL basic_t1_tlast got %b want 0", sif.m_tlast); end
    checks++; if (reset_acc !== 1'b1) begin errors++; $display("[TB] FAIL basic_t1_racc got %b want 1", reset_acc); end
    acc_done = 1'b0; in_data = {D, C};
    step();
    checks++; if (sif.m_tdata !== B) begin errors++; $display("[TB] FAIL basic_t2_tdata got %h want %h", sif.m_tdata, B); end
    checks++; if (sif.m_tlast !== 1'b1) begin errors++; $display("[TB] FAIL basic_t2_tlast got %b want 1", sif.m_tlast); end
    checks++; if (reset_acc !== 1'b0) begin errors++; $display("[TB] FAIL basic_t2_racc got %b want 0", reset_acc); end
    step();
    checks++; if (sif.m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL basic_t3_tvalid got %b want 0", sif.m_tvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_t3_busy got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    in_data = {B, A}; sif.m_tready = 1'b0; acc_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      acc_done = 1'b0;
      checks++; if (sif.m_tvalid !== 1'b1) begin errors++; $display("[TB] FAIL bp_tvalid cyc %0d got %b want 1", i, sif.m_tvalid); end
      checks++; if (sif.m_tdata !== A) begin errors++; $display("[TB] FAIL bp_tdata cyc %0d got %h want %h", i, sif.m_tdata, A); end
    end
    sif.m_tready = 1'b1;
    step();
    checks++; if (sif.m_tdata !== B || sif.m_tlast !== 1'b1) begin errors++; $display("[TB] FAIL bp_chunk1 got %h/%b want %h/1", sif.m_tdata, sif.m_tlast, B); end
    step();
    checks++; if (sif.m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL bp_done_tvalid got %b want 0", sif.m_tvalid); end
  endtask

  task automatic test_held_level();
    int beats = 0;
    int pulses = 0;
    in_data = {B, A}; sif.m_tready = 1'b1; acc_done = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i == 10) acc_done = 1'b0;
      step();
      if (sif.m_tvalid === 1'b1 && sif.m_tready === 1'b1) beats++;
      if (reset_acc === 1'b1) pulses++;
    end
    checks++; if (beats != 2) begin errors++; $display("[TB] FAIL held_beats got %0d want 2", beats); end
    checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL held_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_overflow();
    in_data = {B, A}; sif.m_tready = 1'b0; acc_done = 1'b1;
    step();
    acc_done = 1'b0;
    step();
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_before got %b want 0", overflow); end
    in_data = {D, C}; acc_done = 1'b1;
    step();
    acc_done = 1'b0;
`ifdef CORE_OUT_DBUF_EN
    checks++; if (overflow !== 1'b0 || reset_acc !== 1'b1) begin errors++; $display("[TB] FAIL dbuf_second ovf/racc got %b/%b want 0/1", overflow, reset_acc); end
    step();
    in_data = {B, B}; acc_done = 1'b1;
    step();
    acc_done = 1'b0;
`endif
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set got %b want 1", overflow); end
    checks++; if (reset_acc !== 1'b0) begin errors++; $display("[TB] FAIL ovf_racc got %b want 0", reset_acc); end
    checks++; if (sif.m_tdata !== A) begin errors++; $display("[TB] FAIL ovf_intact got %h want %h", sif.m_tdata, A); end
    sif.m_tready = 1'b1;
    step();
    checks++; if (sif.m_tdata !== B || sif.m_tlast !== 1'b1) begin errors++; $display("[TB] FAIL ovf_chunk1 got %h/%b want %h/1", sif.m_tdata, sif.m_tlast, B); end
`ifdef CORE_OUT_DBUF_EN
    step();
    checks++; if (sif.m_tvalid !== 1'b1 || sif.m_tdata !== C || sif.m_tlast !== 1'b0) begin errors++; $display("[TB] FAIL dbuf_nogap got %b/%h want 1/%h", sif.m_tvalid, sif.m_tdata, C); end
    step();
    checks++; if (sif.m_tdata !== D || sif.m_tlast !== 1'b1) begin errors++; $display("[TB] FAIL dbuf_chunk1 got %h/%b want %h/1", sif.m_tdata, sif.m_tlast, D); end
`endif
    step();
    checks++; if (sif.m_tvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL ovf_drained tvalid/busy got %b/%b want 0/0", sif.m_tvalid, busy); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_mid_reset();
    in_data = {B, A}; sif.m_tready = 1'b1; acc_done = 1'b1;
    step();
    step();
    checks++; if (sif.m_tdata !== B) begin errors++; $display("[TB] FAIL mid_pre got %h want %h", sif.m_tdata, B); end
    rst_n = 1'b0;
    #1;
    checks++; if (sif.m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL mid_tvalid got %b want 0", sif.m_tvalid); end
    checks++; if (overflow !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_flags ovf/busy got %b/%b want 0/0", overflow, busy); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (sif.m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_idle cyc %0d got %b want 0", i, sif.m_tvalid); end
    end
    acc_done = 1'b0;
    step();
    acc_done = 1'b1;
    step();
    acc_done = 1'b0;
    checks++; if (sif.m_tvalid !== 1'b1 || sif.m_tdata !== A) begin errors++; $display("[TB] FAIL post_reset_capture got %b/%h want 1/%h", sif.m_tvalid, sif.m_tdata, A); end
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_held_level();
    test_overflow();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
